unified_mem_arbiter: RTL and testbench

- Shares one single-port instruction/data memory between two requesters: the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between both pipeline stages and the memory macro.
- Allows one transaction in flight at a time. Data requests have priority, with an anti-starvation limit for fetch.
- Includes a response timeout with an error pulse, so the pipeline never hangs on a missing memory response.

---
 rtl/unified_mem_arbiter_if.sv | 40 ++++
 rtl/unified_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory macro.
// slave is the arbiter view; master is the view of the requesters plus memory.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, one
// transaction in flight; data has priority, fetch is forced after MAX_D_STREAK.
module unified_mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input logic                  clk,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);

  // state   | meaning
  // IDLE    | no transaction outstanding, grants allowed
  // BUSY_IF | fetch read outstanding at the memory
  // BUSY_D  | data load/store outstanding at the memory
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  streak_q;
  logic [7:0]  tmo_cnt_q;
  logic        busy;
  logic        force_if;
  logic        tmo_hit;
  logic        d_gnt;
  logic        if_gnt;

  assign busy     = (state_q != IDLE);
  assign force_if = (streak_q == 4'(MAX_D_STREAK));
  // A response in the limit cycle wins over the abort.
  assign tmo_hit  = busy && !bus.mem_rvalid && (tmo_cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_gnt) begin
          state_d = BUSY_D;
        end else if (if_gnt) begin
          state_d = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (bus.mem_rvalid || tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d_gnt  = 1'b0;
    if_gnt = 1'b0;
    if (state_q == IDLE) begin
      d_gnt  = bus.d_req && !(bus.if_req && force_if);
      if_gnt = bus.if_req && !d_gnt;
    end
  end

  assign bus.d_gnt  = d_gnt;
  assign bus.if_gnt = if_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q      <= '0;
      tmo_cnt_q     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.bus_err   <= 1'b0;
    end else begin
      bus.mem_req   <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.bus_err   <= 1'b0;
      if (d_gnt) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_be    <= bus.d_we ? bus.d_be : 4'hF;
        tmo_cnt_q     <= '0;
        streak_q      <= bus.if_req ? streak_q + 4'd1 : 4'd0;
      end else if (if_gnt) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.if_addr;
        bus.mem_be    <= 4'hF;
        tmo_cnt_q     <= '0;
        streak_q      <= '0;
      end else if (busy) begin
        if (bus.mem_rvalid || tmo_hit) begin
          if (state_q == BUSY_IF) begin
            bus.if_rvalid <= 1'b1;
            bus.if_rdata  <= bus.mem_rvalid ? bus.mem_rdata : 32'h0;
          end else begin
            bus.d_rvalid <= 1'b1;
            bus.d_rdata  <= (bus.mem_rvalid && !bus.mem_we) ? bus.mem_rdata : 32'h0;
          end
          bus.bus_err <= tmo_hit;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: scenario tasks plus a response scoreboard fed at
// grant time and drained by a monitor whenever an rvalid appears.
module tb_unified_mem_arbiter;
  localparam int MAX_D_STREAK = 4;
  localparam int TIMEOUT      = 16;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          checks = 0;
  int          failures = 0;
  rsp_t        sb[$];
  int          mem_lat = 1;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_data = '0;
  rsp_t        mon_e;
  logic [34:0] mon_obs, mon_exp;

  unified_mem_arbiter_if bus();

  unified_mem_arbiter #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void push_rsp(input bit is_d, input bit err, input logic [31:0] rdata);
    rsp_t e;
    e.is_d  = is_d;
    e.err   = err;
    e.rdata = rdata;
    sb.push_back(e);
  endfunction

  function automatic logic [138:0] out_vec();
    return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
            bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata, bus.bus_err,
            bus.if_gnt, bus.d_gnt};
  endfunction

  // Memory model: answers mem_lat cycles after the mem_req cycle (0 = never).
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rsp_data;
        end
      end
      if (bus.mem_req && mem_lat > 0) begin
        rsp_cnt  = mem_lat;
        rsp_data = fixed_en ? fixed_data : mem_model(bus.mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.if_rvalid || bus.d_rvalid || bus.bus_err) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: if_rvalid=%0b d_rvalid=%0b bus_err=%0b, none expected",
                 bus.if_rvalid, bus.d_rvalid, bus.bus_err);
      end else begin
        mon_e   = sb.pop_front();
        mon_obs = {bus.if_rvalid, bus.d_rvalid, bus.bus_err,
                   mon_e.is_d ? bus.d_rdata : bus.if_rdata};
        mon_exp = {~mon_e.is_d, mon_e.is_d, mon_e.err, mon_e.rdata};
        if (mon_obs !== mon_exp) begin
          failures++;
          $display("FAIL rsp_content: got {ifv,dv,err,rdata}=%h expected %h", mon_obs, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_vec() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", out_vec());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec() !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h expected 0", out_vec());
    end
  endtask

  task automatic test_single_fetch();
    int seen = -1;
    bit d_seen = 1'b0;
    mem_lat    = 2;
    fixed_en   = 1'b1;
    fixed_data = 32'h0050_0093;
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_grant: got if_gnt,d_gnt=%b expected 10", {bus.if_gnt, bus.d_gnt});
    end
    push_rsp(1'b0, 1'b0, 32'h0050_0093);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      failures++;
      $display("FAIL fetch_cmd: got req=%0b we=%0b addr=%h be=%h expected 1 0 00000100 f",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be);
    end
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (bus.if_rvalid && seen < 0) seen = c;
      if (bus.d_rvalid) d_seen = 1'b1;
    end
    checks++;
    if (seen != 4) begin
      failures++;
      $display("FAIL fetch_latency: if_rvalid at cycle %0d expected 4", seen);
    end
    checks++;
    if (d_seen) begin
      failures++;
      $display("FAIL fetch_no_d_rvalid: d_rvalid=1 expected 0");
    end
    fixed_en = 1'b0;
  endtask

  task automatic test_store();
    int seen = -1;
    mem_lat = 1;
    @(posedge clk); #1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_2000;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_be    = 4'b0011;
    @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL store_grant: got if_gnt,d_gnt=%b expected 01", {bus.if_gnt, bus.d_gnt});
    end
    push_rsp(1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !==
        {1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011}) begin
      failures++;
      $display("FAIL store_cmd: got req=%0b we=%0b addr=%h wdata=%h be=%h expected 1 1 00002000 deadbeef 3",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      if (bus.d_rvalid && seen < 0) seen = c;
    end
    checks++;
    if (seen != 3) begin
      failures++;
      $display("FAIL store_latency: d_rvalid at cycle %0d expected 3", seen);
    end
  endtask

  task automatic test_contention();
    bit exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int n = 0;
    int guard = 0;
    bit was_d;
    mem_lat = 1;
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_1000;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_8000;
    bus.d_be    = 4'hF;
    while (n < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.d_gnt || bus.if_gnt) begin
        checks++;
        if (bus.d_gnt !== exp_d[n]) begin
          failures++;
          $display("FAIL contention_order: grant %0d got d_gnt=%0b expected %0b", n, bus.d_gnt, exp_d[n]);
        end
        was_d = bus.d_gnt;
        if (was_d) push_rsp(1'b1, 1'b0, mem_model(bus.d_addr));
        else       push_rsp(1'b0, 1'b0, mem_model(bus.if_addr));
        @(posedge clk); #1;
        if (was_d) bus.d_addr = bus.d_addr + 32'd4;
        else       bus.if_addr = bus.if_addr + 32'd4;
        n++;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL contention_grants: got %0d grants expected 10", n);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL contention_drain: %0d responses missing expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    int seen = -1;
    bit gnt_early = 1'b0;
    bit gnt_at_rsp = 1'b0;
    bit got = 1'b0;
    mem_lat = 0;
    @(posedge clk); #1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_4000;
    bus.d_be   = 4'h1;
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      failures++;
      $display("FAIL timeout_grant: got d_gnt=%0b expected 1", bus.d_gnt);
    end
    push_rsp(1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    bus.d_req   = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0180;
    @(negedge clk);
    for (int c = 2; c <= 30 && seen < 0; c++) begin
      @(negedge clk);
      if (bus.d_rvalid) begin
        seen = c;
        gnt_at_rsp = bus.if_gnt;
      end else if (bus.if_gnt) begin
        gnt_early = 1'b1;
      end
    end
    mem_lat = 1;
    checks++;
    if (seen != 17) begin
      failures++;
      $display("FAIL timeout_latency: d_rvalid at cycle %0d expected 17", seen);
      sb.delete();
    end
    checks++;
    if (gnt_early) begin
      failures++;
      $display("FAIL busy_grant: if_gnt=1 while busy expected 0");
    end
    checks++;
    if (!gnt_at_rsp) begin
      failures++;
      $display("FAIL grant_in_rvalid_cycle: if_gnt=0 expected 1");
    end
    if (gnt_at_rsp) push_rsp(1'b0, 1'b0, mem_model(32'h0000_0180));
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    if (gnt_at_rsp) begin
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        got = bus.if_rvalid;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL after_timeout_fetch: if_rvalid=0 expected 1");
        sb.delete();
      end
    end
  endtask

  task automatic test_timeout_edge();
    int seen = -1;
    bit err_seen = 1'b0;
    mem_lat = TIMEOUT - 1;
    @(posedge clk); #1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h0000_5000;
    bus.d_be   = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      failures++;
      $display("FAIL edge_grant: got d_gnt=%0b expected 1", bus.d_gnt);
    end
    push_rsp(1'b1, 1'b0, mem_model(32'h0000_5000));
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    for (int c = 2; c <= 30 && seen < 0; c++) begin
      @(negedge clk);
      if (bus.bus_err) err_seen = 1'b1;
      if (bus.d_rvalid) seen = c;
    end
    checks++;
    if (seen != 17 || err_seen) begin
      failures++;
      $display("FAIL edge_response: d_rvalid cycle %0d bus_err=%0b expected cycle 17 bus_err=0", seen, err_seen);
      sb.delete();
    end
    mem_lat = 1;
  endtask

  task automatic test_reset_mid_op();
    bit stray = 1'b0;
    bit got = 1'b0;
    mem_lat = 6;
    @(posedge clk); #1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_3000;
    bus.d_wdata = 32'h1234_5678;
    bus.d_be    = 4'hF;
    @(negedge clk);
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midreset_grant: got d_gnt=%0b expected 1", bus.d_gnt);
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_vec() !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got %h expected 0", out_vec());
    end
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (bus.if_rvalid || bus.d_rvalid || bus.bus_err) stray = 1'b1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL midreset_stray: rvalid/bus_err=1 after reset expected 0");
    end
    mem_lat = 1;
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midreset_fresh_grant: got if_gnt=%0b expected 1", bus.if_gnt);
    end
    if (bus.if_gnt === 1'b1) push_rsp(1'b0, 1'b0, mem_model(32'h0000_0200));
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.if_rvalid;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL midreset_fetch_rsp: if_rvalid=0 expected 1");
      sb.delete();
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
